// File: rtl/ps2_frame_receiver.sv
// PS/2-style frame receiver: pin sync + debounce, start/data/parity/stop deframing,
// timeout abort and a FWFT output queue. Optional clock-inhibit via PS2_RX_INHIBIT_EN.

module ps2_line_filter #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] != filt) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    filt <= sync[1];
                    cnt  <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end
endmodule

module ps2_frame_receiver #(
    parameter int DATA_WIDTH      = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int TIMEOUT_CYCLES  = 50000,
    parameter int FIFO_DEPTH      = 4,
    parameter int PARITY_ODD      = 1
) (
    input  logic                          FCLK,
    input  logic                          RST,
    input  logic                          SER_CLK,
    input  logic                          SER_DATA,
    output logic [DATA_WIDTH-1:0]         DATA_OUT,
    output logic                          DATA_PARITY_ERR,
    output logic                          DATA_VALID,
    input  logic                          DATA_READY,
    output logic                          FRAME_ERROR,
    output logic                          OVERFLOW,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_LEVEL,
    output logic                          SER_CLK_HOLD
);
    localparam int   BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam int   TCW = $clog2(TIMEOUT_CYCLES + 1);
    localparam int   PW  = $clog2(FIFO_DEPTH);
    localparam int   LW  = PW + 1;
    localparam logic ODD = (PARITY_ODD != 0);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  perr;
    } fifo_entry_t;

    // line 0 = serial clock, line 1 = serial data
    logic [1:0] raw_lines, filt_lines;
    assign raw_lines = {SER_DATA, SER_CLK};

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_line
            ps2_line_filter #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_filt (
                .clk  (FCLK),
                .rst  (RST),
                .raw  (raw_lines[g]),
                .filt (filt_lines[g])
            );
        end
    endgenerate

    logic clk_prev, strobe, sdata;
    assign strobe = clk_prev & ~filt_lines[0];
    assign sdata  = filt_lines[1];

    state_t                state, state_n;
    logic [BCW-1:0]        bit_cnt;
    logic [DATA_WIDTH-1:0] shift_r;
    logic                  par_r;
    logic [TCW-1:0]        to_cnt;
    logic                  timeout, push_n, frame_err_n;
    logic                  push_req, frame_err_r;
    fifo_entry_t           push_entry;

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n     = state;
        push_n      = 1'b0;
        frame_err_n = 1'b0;
        // a strobe in the expiry cycle counts as activity and suppresses the abort
        timeout     = (state != IDLE) && !strobe && (to_cnt == TCW'(TIMEOUT_CYCLES - 1));
        case (state)
            IDLE:    if (strobe && !sdata) state_n = DATA;
            DATA:    if (strobe && bit_cnt == BCW'(DATA_WIDTH - 1)) state_n = PARITY;
            PARITY:  if (strobe) state_n = STOP;
            STOP: begin
                if (strobe) begin
                    state_n     = IDLE;
                    push_n      = sdata;
                    frame_err_n = !sdata;
                end
            end
            default: state_n = IDLE;
        endcase
        if (timeout) begin
            state_n     = IDLE;
            frame_err_n = 1'b1;
        end
    end

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            clk_prev    <= 1'b1;
            bit_cnt     <= '0;
            shift_r     <= '0;
            par_r       <= 1'b0;
            to_cnt      <= '0;
            push_req    <= 1'b0;
            push_entry  <= '0;
            frame_err_r <= 1'b0;
        end else begin
            clk_prev <= filt_lines[0];
            if (state == IDLE || strobe) to_cnt <= '0;
            else                         to_cnt <= to_cnt + TCW'(1);
            if (timeout) begin
                shift_r <= '0;
                bit_cnt <= '0;
            end else if (strobe) begin
                case (state)
                    IDLE:   bit_cnt <= '0;
                    DATA: begin
                        shift_r[bit_cnt] <= sdata;
                        bit_cnt          <= bit_cnt + BCW'(1);
                    end
                    PARITY: par_r <= sdata;
                    default: ;
                endcase
            end
            push_req        <= push_n;
            push_entry.data <= shift_r;
            push_entry.perr <= (^{shift_r, par_r}) != ODD;
            frame_err_r     <= frame_err_n;
        end
    end

    assign FRAME_ERROR = frame_err_r;

    // output queue: registered head so DATA_OUT is glitch-free and valid with DATA_VALID
    fifo_entry_t       mem [FIFO_DEPTH];
    fifo_entry_t       head_r, head_n;
    logic [PW-1:0]     wr_ptr, rd_ptr, rd_n;
    logic [LW-1:0]     level, level_n;
    logic              full, pop, do_push, ovf_r;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign pop     = DATA_VALID & DATA_READY;
    assign do_push = push_req & (~full | pop);

    always_comb begin
        rd_n    = rd_ptr + PW'(pop);
        level_n = level + LW'(do_push) - LW'(pop);
        head_n  = head_r;
        if (level_n != '0)
            head_n = (do_push && wr_ptr == rd_n) ? push_entry : mem[rd_n];
    end

    always_ff @(posedge FCLK) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            head_r <= '0;
            ovf_r  <= 1'b0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            rd_ptr <= rd_n;
            level  <= level_n;
            head_r <= head_n;
            ovf_r  <= push_req & full & ~pop;
        end
    end

    assign DATA_OUT        = head_r.data;
    assign DATA_PARITY_ERR = head_r.perr;
    assign DATA_VALID      = (level != '0);
    assign FIFO_LEVEL      = level;
    assign OVERFLOW        = ovf_r;

`ifdef PS2_RX_INHIBIT_EN
    logic hold_r;
    always_ff @(posedge FCLK or posedge RST) begin
        if (RST) hold_r <= 1'b0;
        else     hold_r <= (level_n == LW'(FIFO_DEPTH)) && (state_n == IDLE);
    end
    assign SER_CLK_HOLD = hold_r;
`else
    assign SER_CLK_HOLD = 1'b0;
`endif
endmodule

// File: tb/tb_ps2_frame_receiver.sv
// Directed bench for ps2_frame_receiver: clean/parity/stop errors, glitch, timeout,
// overflow and mid-frame reset.
module tb_ps2_frame_receiver;
    localparam int DW = 8;
    localparam int TO = 2000;

    logic          FCLK = 1'b0;
    logic          RST = 1'b1;
    logic          SER_CLK = 1'b1;
    logic          SER_DATA = 1'b1;
    logic          DATA_READY = 1'b0;
    logic [DW-1:0] DATA_OUT;
    logic          DATA_PARITY_ERR, DATA_VALID, FRAME_ERROR, OVERFLOW, SER_CLK_HOLD;
    logic [2:0]    FIFO_LEVEL;

    int passed = 0;
    int total  = 0;
    int fe_cnt = 0;
    int ovf_cnt = 0;

    ps2_frame_receiver #(
        .DATA_WIDTH(DW), .DEBOUNCE_CYCLES(16), .TIMEOUT_CYCLES(TO),
        .FIFO_DEPTH(4), .PARITY_ODD(1)
    ) dut (
        .FCLK(FCLK), .RST(RST), .SER_CLK(SER_CLK), .SER_DATA(SER_DATA),
        .DATA_OUT(DATA_OUT), .DATA_PARITY_ERR(DATA_PARITY_ERR), .DATA_VALID(DATA_VALID),
        .DATA_READY(DATA_READY), .FRAME_ERROR(FRAME_ERROR), .OVERFLOW(OVERFLOW),
        .FIFO_LEVEL(FIFO_LEVEL), .SER_CLK_HOLD(SER_CLK_HOLD)
    );

    always #5 FCLK = ~FCLK;

    always @(posedge FCLK) begin
        if (FRAME_ERROR) fe_cnt++;
        if (OVERFLOW)    ovf_cnt++;
    end

    task automatic check(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge FCLK);
    endtask

    // bits[0] goes out first; data changes while the clock is high
    task automatic send_bits(input logic [10:0] bits, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            SER_DATA = bits[i];
            wait_cyc(half);
            SER_CLK = 1'b0;
            wait_cyc(half);
            SER_CLK = 1'b1;
        end
        SER_DATA = 1'b1;
        wait_cyc(half);
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic par_flip, input logic stop);
        logic p;
        p = ~(^d) ^ par_flip;
        return {stop, p, d, 1'b0};
    endfunction

    task automatic pop_one;
        @(negedge FCLK);
        DATA_READY = 1'b1;
        @(negedge FCLK);
        DATA_READY = 1'b0;
        wait_cyc(1);
    endtask

    initial begin
        int fe0, ovf0, waited;
        logic [7:0] exp_d;

        // reset state
        wait_cyc(5);
        check("rst_data_out", DATA_OUT, 0);
        check("rst_perr", DATA_PARITY_ERR, 0);
        check("rst_valid", DATA_VALID, 0);
        check("rst_frame_err", FRAME_ERROR, 0);
        check("rst_overflow", OVERFLOW, 0);
        check("rst_level", FIFO_LEVEL, 0);
        check("rst_hold", SER_CLK_HOLD, 0);
        RST = 1'b0;
        wait_cyc(20);

        // clean 0x1C at 800-cycle bit period
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 400);
        check("clean_valid", DATA_VALID, 1);
        check("clean_data", DATA_OUT, 8'h1C);
        check("clean_perr", DATA_PARITY_ERR, 0);
        check("clean_level1", FIFO_LEVEL, 1);
        pop_one();
        check("clean_level0", FIFO_LEVEL, 0);
        check("clean_valid0", DATA_VALID, 0);

        // bad parity: still queued, flagged, no frame error
        fe0 = fe_cnt;
        send_bits(frame(8'h1C, 1'b1, 1'b1), 11, 200);
        check("perr_data", DATA_OUT, 8'h1C);
        check("perr_flag", DATA_PARITY_ERR, 1);
        check("perr_no_fe", fe_cnt - fe0, 0);
        pop_one();

        // bad stop bit: dropped, single-cycle FRAME_ERROR, then 0xF0 recovers
        fe0 = fe_cnt;
        send_bits(frame(8'h33, 1'b0, 1'b0), 11, 200);
        check("stop0_level", FIFO_LEVEL, 0);
        check("stop0_fe_cycles", fe_cnt - fe0, 1);
        send_bits(frame(8'hF0, 1'b0, 1'b1), 11, 200);
        check("f0_level", FIFO_LEVEL, 1);
        check("f0_data", DATA_OUT, 8'hF0);
        check("f0_perr", DATA_PARITY_ERR, 0);
        pop_one();

        // 5-cycle clock glitch with data low must not open a frame
        fe0 = fe_cnt;
        SER_DATA = 1'b0;
        wait_cyc(40);
        SER_CLK = 1'b0;
        wait_cyc(5);
        SER_CLK = 1'b1;
        wait_cyc(40);
        SER_DATA = 1'b1;
        wait_cyc(100);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 11, 200);
        check("glitch_level", FIFO_LEVEL, 1);
        check("glitch_data", DATA_OUT, 8'h1C);
        check("glitch_no_fe", fe_cnt - fe0, 0);
        pop_one();

        // timeout after start + 4 data bits
        fe0 = fe_cnt;
        send_bits(frame(8'hFF, 1'b0, 1'b1), 5, 200);
        waited = 400;
        while (fe_cnt == fe0 && waited < TO + 1000) begin
            wait_cyc(1);
            waited++;
        end
        check("timeout_seen", int'(waited >= TO && waited <= TO + 40), 1);
        check("timeout_fe_cycles", fe_cnt - fe0, 1);
        check("timeout_level", FIFO_LEVEL, 0);

        // overflow: five frames into a four-deep queue with no consumer
        ovf0 = ovf_cnt;
        for (int i = 1; i <= 5; i++) send_bits(frame(8'(i), 1'b0, 1'b1), 11, 200);
        check("ovf_level", FIFO_LEVEL, 4);
        check("ovf_pulses", ovf_cnt - ovf0, 1);
        check("ovf_hold", SER_CLK_HOLD, 0);
        for (int i = 1; i <= 4; i++) begin
            exp_d = 8'(i);
            check("ovf_pop_data", DATA_OUT, exp_d);
            pop_one();
        end
        check("ovf_drained", FIFO_LEVEL, 0);

        // reset during bit 3 with two entries queued
        send_bits(frame(8'h11, 1'b0, 1'b1), 11, 200);
        send_bits(frame(8'h22, 1'b0, 1'b1), 11, 200);
        check("pre_rst_level", FIFO_LEVEL, 2);
        send_bits(frame(8'h5A, 1'b0, 1'b1), 4, 200);
        SER_DATA = 1'b1;
        wait_cyc(100);
        SER_CLK = 1'b0;
        wait_cyc(100);
        RST = 1'b1;
        #1;
        check("mid_rst_level", FIFO_LEVEL, 0);
        check("mid_rst_valid", DATA_VALID, 0);
        check("mid_rst_data", DATA_OUT, 0);
        check("mid_rst_perr", DATA_PARITY_ERR, 0);
        SER_CLK = 1'b1;
        wait_cyc(5);
        RST = 1'b0;
        wait_cyc(50);
        send_bits(frame(8'h5A, 1'b0, 1'b1), 11, 200);
        check("post_rst_level", FIFO_LEVEL, 1);
        check("post_rst_data", DATA_OUT, 8'h5A);
        check("post_rst_perr", DATA_PARITY_ERR, 0);
        pop_one();
        check("post_rst_empty", FIFO_LEVEL, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/ps2_frame_receiver.md
Name: ps2_frame_receiver

Overview:
- Parametrised successor to the keyboard scan-code front end. Whole design runs from one fast clock.
- Synchronises and debounces the serial clock and data lines, then detects falling edges of the serial clock.
- Deframes start/data/parity/stop frames, checks parity, stop bit and inter-bit timeout.
- Queues good frames in a small FIFO with a valid/ready output; sits between the board pins and the scan-code decoder.

Parameters:
DATA_WIDTH, 8, data bits per frame, LSB first
DEBOUNCE_CYCLES, 16, consecutive stable FCLK cycles before the filtered line changes (>=2)
TIMEOUT_CYCLES, 50000, FCLK cycles without a serial-clock falling edge before an open frame is aborted
FIFO_DEPTH, 4, output queue entries (power of two, >=2)
PARITY_ODD, 1, 1 = odd parity, 0 = even parity

Ports:
FCLK  in  1  system clock; all logic on its rising edge
RST  in  1  asynchronous, active-high reset
SER_CLK  in  1  raw serial clock pin, asynchronous
SER_DATA  in  1  raw serial data pin, asynchronous
DATA_OUT  out  DATA_WIDTH  head-of-FIFO frame data
DATA_PARITY_ERR  out  1  head-of-FIFO frame failed parity
DATA_VALID  out  1  FIFO not empty
DATA_READY  in  1  consumer accepts head entry
FRAME_ERROR  out  1  one-cycle pulse on bad stop bit or timeout
OVERFLOW  out  1  one-cycle pulse when a completed frame is dropped because the FIFO is full
FIFO_LEVEL  out  $clog2(FIFO_DEPTH)+1  entries held
SER_CLK_HOLD  out  1  request to pull the serial clock low (see Optional Feature)

Behaviour:
- Reset values: DATA_OUT=0, DATA_PARITY_ERR=0, DATA_VALID=0, FRAME_ERROR=0, OVERFLOW=0, FIFO_LEVEL=0, SER_CLK_HOLD=0.
- Reset state: FSM=IDLE; filtered lines=1; sync flops=1.
- Each pin passes through a 2-flop synchroniser, then a debounce counter.
- Debounce: the filtered value takes the synced value after DEBOUNCE_CYCLES consecutive cycles of disagreement. Any agreement clears the counter.
- Falling edge: filtered clock 1 in the previous cycle and 0 in the current cycle gives a one-cycle strobe. Filtered data is sampled on that strobe.
- FSM states: IDLE, DATA, PARITY, STOP.
- IDLE: on strobe with data=0, go to DATA and clear the bit counter. Data=1 is ignored and FSM stays IDLE.
- DATA: shift the sample into bit[count]. After DATA_WIDTH strobes, go to PARITY.
- PARITY: store the sample and go to STOP.
- Parity error is set when the XOR of the data bits and the parity bit is not equal to PARITY_ODD.
- STOP, sample=1: push {data, parity_err} and go to IDLE.
- STOP, sample=0: drop the frame, pulse FRAME_ERROR and go to IDLE.
- Timeout: a counter runs in any state other than IDLE and clears on each strobe. At TIMEOUT_CYCLES: go to IDLE, pulse FRAME_ERROR, discard partial data.
- Timeout and strobe in the same cycle: the strobe wins.
- Latency: push happens in the cycle after the stop strobe. DATA_VALID rises the cycle after that.
- FIFO is first-word-fall-through. DATA_OUT and DATA_PARITY_ERR are registered head values and are valid whenever DATA_VALID=1.
- Pop occurs on DATA_VALID & DATA_READY.
- Push while full with no pop: the frame is dropped and OVERFLOW pulses.
- Push while full with a simultaneous pop: both happen, the level is unchanged and there is no overflow.
- Pop while empty: ignored.
- Pointers wrap modulo FIFO_DEPTH.
- FIFO_LEVEL is exact and saturates at FIFO_DEPTH.
- Reset mid-frame: everything above returns to its reset value immediately. The partial frame is lost and the FIFO is emptied.

Optional Feature:
- Macro PS2_RX_INHIBIT_EN.
- Defined: SER_CLK_HOLD=1 while FIFO_LEVEL==FIFO_DEPTH and FSM=IDLE. It is registered and drops the cycle after a pop. The board drives the clock line low through an open drain, so the device holds off and no overflow occurs in normal use.
- Undefined: SER_CLK_HOLD is tied to 0; overflow behaviour is as above.

Test Plan:
- Clean frame 0x1C, odd parity: start 0, bits 0,0,1,1,1,0,0,0, parity 0, stop 1, bit period 800 FCLK -> DATA_VALID=1 with DATA_OUT=0x1C, DATA_PARITY_ERR=0; DATA_READY=1 gives FIFO_LEVEL 1->0.
- Same frame with parity bit 1 -> entry 0x1C queued with DATA_PARITY_ERR=1; FRAME_ERROR stays 0.
- Stop bit 0 -> nothing queued, FRAME_ERROR pulses for exactly 1 cycle, FSM returns to IDLE; the next clean 0xF0 frame is received correctly.
- 5-cycle glitch on SER_CLK with DEBOUNCE_CYCLES=16 -> no strobe, FSM stays IDLE. Stop clocking after 4 data bits -> FRAME_ERROR pulses TIMEOUT_CYCLES after the last edge.
- DATA_READY=0, send 5 frames 0x01..0x05 with FIFO_DEPTH=4 -> FIFO_LEVEL=4 and one OVERFLOW pulse on frame 5 (macro undefined). With the macro defined, SER_CLK_HOLD=1 after frame 4. Pops then return 0x01..0x04 in order.
- Assert RST during bit 3 of a frame with 2 entries queued -> all outputs return to reset values immediately; the following clean 0x5A frame is received as the only entry.
